// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : Round-robin arbiter sharing one memory port between IFU and LSU,
//            one outstanding transaction, grant held until the response is taken.
//            Optional macro ARB_TIMEOUT_EN adds a response watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_req_addr,
    output logic                  ifu_resp_valid,
    input  logic                  ifu_resp_ready,
    output logic [DATA_W-1:0]     ifu_resp_data,
    output logic                  ifu_resp_err,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_req_addr,
    input  logic                  lsu_req_wen,
    input  logic [DATA_W-1:0]     lsu_req_wdata,
    input  logic [DATA_W/8-1:0]   lsu_req_wstrb,
    output logic                  lsu_resp_valid,
    input  logic                  lsu_resp_ready,
    output logic [DATA_W-1:0]     lsu_resp_data,
    output logic                  lsu_resp_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wstrb,
    input  logic                  mem_resp_valid,
    output logic                  mem_resp_ready,
    input  logic [DATA_W-1:0]     mem_resp_data,
    input  logic                  mem_resp_err,
    output logic                  grant_lsu
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   grant_lsu_q, grant_lsu_d;
    logic   last_lsu_q, last_lsu_d;

    logic              w_tmo;
    logic              w_rsp_valid;
    logic [DATA_W-1:0] w_rsp_data;
    logic              w_rsp_err;

`ifdef ARB_TIMEOUT_EN
    localparam int                CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  c_TMO = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counter saturates at the limit so the synthesized error stays asserted.
    assign w_tmo = (state_q == S_RESP) && (tmo_cnt_q == c_TMO);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q != S_RESP) begin
            tmo_cnt_d = '0;
        end else if (!mem_resp_valid && !w_tmo) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    assign w_rsp_valid = w_tmo | mem_resp_valid;
    assign w_rsp_data  = w_tmo ? '0 : mem_resp_data;
    assign w_rsp_err   = w_tmo | mem_resp_err;
    assign grant_lsu   = grant_lsu_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            grant_lsu_q <= 1'b0;
            last_lsu_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            grant_lsu_q <= grant_lsu_d;
            last_lsu_q  <= last_lsu_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_lsu_d    = grant_lsu_q;
        last_lsu_d     = last_lsu_q;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_resp_data  = '0;
        ifu_resp_err   = 1'b0;
        lsu_resp_valid = 1'b0;
        lsu_resp_data  = '0;
        lsu_resp_err   = 1'b0;
        mem_req_valid  = 1'b0;
        mem_req_addr   = '0;
        mem_req_wen    = 1'b0;
        mem_req_wdata  = '0;
        mem_req_wstrb  = '0;
        mem_resp_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Contention goes to whichever master was not served last.
                if (ifu_req_valid || lsu_req_valid) begin
                    grant_lsu_d = (ifu_req_valid && lsu_req_valid) ? ~last_lsu_q
                                                                   : lsu_req_valid;
                    state_d     = S_REQ;
                end
            end

            S_REQ: begin
                if (grant_lsu_q) begin
                    mem_req_valid = lsu_req_valid;
                    mem_req_addr  = lsu_req_addr;
                    mem_req_wen   = lsu_req_wen;
                    mem_req_wdata = lsu_req_wdata;
                    mem_req_wstrb = lsu_req_wstrb;
                    lsu_req_ready = mem_req_ready;
                end else begin
                    mem_req_valid = ifu_req_valid;
                    mem_req_addr  = ifu_req_addr;
                    ifu_req_ready = mem_req_ready;
                end
                if (mem_req_valid && mem_req_ready) begin
                    state_d    = S_RESP;
                    last_lsu_d = grant_lsu_q;
                end
            end

            S_RESP: begin
                if (grant_lsu_q) begin
                    lsu_resp_valid = w_rsp_valid;
                    lsu_resp_data  = w_rsp_data;
                    lsu_resp_err   = w_rsp_err;
                    mem_resp_ready = lsu_resp_ready;
                end else begin
                    ifu_resp_valid = w_rsp_valid;
                    ifu_resp_data  = w_rsp_data;
                    ifu_resp_err   = w_rsp_err;
                    mem_resp_ready = ifu_resp_ready;
                end
                if (w_rsp_valid && mem_resp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; inputs change and outputs
// are sampled 1 time unit after the rising edge.
`default_nettype none

module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_resp_data;
    logic        ifu_resp_err;
    logic        lsu_req_valid, lsu_req_ready;
    logic [31:0] lsu_req_addr;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_wdata;
    logic [3:0]  lsu_req_wstrb;
    logic        lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_resp_data;
    logic        lsu_resp_err;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_resp_data;
    logic        mem_resp_err;
    logic        grant_lsu;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_req_addr   (ifu_req_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_ready (ifu_resp_ready),
        .ifu_resp_data  (ifu_resp_data),
        .ifu_resp_err   (ifu_resp_err),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_req_addr   (lsu_req_addr),
        .lsu_req_wen    (lsu_req_wen),
        .lsu_req_wdata  (lsu_req_wdata),
        .lsu_req_wstrb  (lsu_req_wstrb),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_ready (lsu_resp_ready),
        .lsu_resp_data  (lsu_resp_data),
        .lsu_resp_err   (lsu_resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_err   (mem_resp_err),
        .grant_lsu      (grant_lsu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req_valid  = 1'b0;
        ifu_req_addr   = '0;
        ifu_resp_ready = 1'b0;
        lsu_req_valid  = 1'b0;
        lsu_req_addr   = '0;
        lsu_req_wen    = 1'b0;
        lsu_req_wdata  = '0;
        lsu_req_wstrb  = '0;
        lsu_resp_ready = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        mem_resp_err   = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst            = 1'b0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        ifu_req_valid  = 1'b1;
        repeat (2) tick();
        checks++; if (grant_lsu !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b exp 0", grant_lsu); end
        checks++; if (ifu_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ifu_req_ready: got %b exp 0", ifu_req_ready); end
        checks++; if (lsu_req_ready !== 1'b0) begin errors++; $display("FAIL reset_lsu_req_ready: got %b exp 0", lsu_req_ready); end
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %b exp 0", mem_req_valid); end
        checks++; if (mem_resp_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_resp_ready: got %b exp 0", mem_resp_ready); end
        checks++; if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got ifu=%b lsu=%b exp 0/0", ifu_resp_valid, lsu_resp_valid); end
        clear_inputs();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_ifu_read();
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0000;
        mem_req_ready = 1'b1;
        #1;
        checks++; if (ifu_req_ready !== 1'b0) begin errors++; $display("FAIL ifu_bubble_ready: got %b exp 0", ifu_req_ready); end
        tick();
        checks++; if (ifu_req_ready !== 1'b1) begin errors++; $display("FAIL ifu_req_ready: got %b exp 1", ifu_req_ready); end
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL ifu_mem_req: got v=%b a=%h exp 1/80000000", mem_req_valid, mem_req_addr); end
        checks++; if (mem_req_wen !== 1'b0 || mem_req_wdata !== 32'h0 || mem_req_wstrb !== 4'h0) begin errors++; $display("FAIL ifu_write_fields: got wen=%b wd=%h ws=%h exp 0/0/0", mem_req_wen, mem_req_wdata, mem_req_wstrb); end
        checks++; if (grant_lsu !== 1'b0) begin errors++; $display("FAIL ifu_grant: got %b exp 0", grant_lsu); end
        tick();
        ifu_req_valid  = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_0013;
        mem_resp_err   = 1'b0;
        ifu_resp_ready = 1'b1;
        #1;
        checks++; if (ifu_resp_valid !== 1'b1 || ifu_resp_data !== 32'h13 || ifu_resp_err !== 1'b0) begin errors++; $display("FAIL ifu_resp: got v=%b d=%h e=%b exp 1/00000013/0", ifu_resp_valid, ifu_resp_data, ifu_resp_err); end
        checks++; if (mem_resp_ready !== 1'b1) begin errors++; $display("FAIL ifu_mem_resp_ready: got %b exp 1", mem_resp_ready); end
        checks++; if (lsu_resp_valid !== 1'b0 || lsu_resp_data !== 32'h0) begin errors++; $display("FAIL ifu_nonowner_resp: got v=%b d=%h exp 0/0", lsu_resp_valid, lsu_resp_data); end
        tick();
        checks++; if (ifu_resp_valid !== 1'b0 || mem_resp_ready !== 1'b0) begin errors++; $display("FAIL ifu_resp_after_idle: got v=%b r=%b exp 0/0", ifu_resp_valid, mem_resp_ready); end
        clear_inputs();
    endtask

    task automatic test_both();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        tick();
        ifu_req_valid  = 1'b1;
        ifu_req_addr   = 32'h0000_0100;
        lsu_req_valid  = 1'b1;
        lsu_req_addr   = 32'h0000_0020;
        mem_req_ready  = 1'b1;
        ifu_resp_ready = 1'b1;
        lsu_resp_ready = 1'b1;
        tick();
        checks++; if (grant_lsu !== 1'b0 || ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin errors++; $display("FAIL both_first_grant: got g=%b ir=%b lr=%b exp 0/1/0", grant_lsu, ifu_req_ready, lsu_req_ready); end
        checks++; if (mem_req_addr !== 32'h100) begin errors++; $display("FAIL both_first_addr: got %h exp 00000100", mem_req_addr); end
        tick();
        ifu_req_valid  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h1111_1111;
        #1;
        checks++; if (ifu_resp_data !== 32'h1111_1111 || lsu_resp_valid !== 1'b0 || lsu_req_ready !== 1'b0) begin errors++; $display("FAIL both_ifu_resp: got d=%h lv=%b lr=%b exp 11111111/0/0", ifu_resp_data, lsu_resp_valid, lsu_req_ready); end
        tick();
        mem_resp_valid = 1'b0;
        #1;
        checks++; if (lsu_req_ready !== 1'b0) begin errors++; $display("FAIL both_idle_bubble: got %b exp 0", lsu_req_ready); end
        tick();
        checks++; if (grant_lsu !== 1'b1 || lsu_req_ready !== 1'b1 || mem_req_addr !== 32'h20 || mem_req_wen !== 1'b0) begin errors++; $display("FAIL both_second_grant: got g=%b lr=%b a=%h w=%b exp 1/1/00000020/0", grant_lsu, lsu_req_ready, mem_req_addr, mem_req_wen); end
        tick();
        lsu_req_valid  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h2222_2222;
        #1;
        checks++; if (lsu_resp_valid !== 1'b1 || lsu_resp_data !== 32'h2222_2222 || ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL both_lsu_resp: got v=%b d=%h iv=%b exp 1/22222222/0", lsu_resp_valid, lsu_resp_data, ifu_resp_valid); end
        tick();
        clear_inputs();
    endtask

    task automatic test_store();
        lsu_req_valid  = 1'b1;
        lsu_req_addr   = 32'h0000_0010;
        lsu_req_wen    = 1'b1;
        lsu_req_wdata  = 32'hDEAD_BEEF;
        lsu_req_wstrb  = 4'hF;
        mem_req_ready  = 1'b1;
        lsu_resp_ready = 1'b1;
        tick();
        checks++; if (mem_req_wen !== 1'b1 || mem_req_addr !== 32'h10 || mem_req_wdata !== 32'hDEAD_BEEF || mem_req_wstrb !== 4'hF) begin errors++; $display("FAIL store_fields: got w=%b a=%h d=%h s=%h exp 1/00000010/deadbeef/f", mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb); end
        checks++; if (grant_lsu !== 1'b1 || lsu_req_ready !== 1'b1) begin errors++; $display("FAIL store_grant: got g=%b r=%b exp 1/1", grant_lsu, lsu_req_ready); end
        tick();
        lsu_req_valid  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_0055;
        #1;
        checks++; if (lsu_resp_valid !== 1'b1 || lsu_resp_err !== 1'b0 || ifu_resp_data !== 32'h0) begin errors++; $display("FAIL store_ack: got v=%b e=%b ifu_d=%h exp 1/0/0", lsu_resp_valid, lsu_resp_err, ifu_resp_data); end
        tick();
        clear_inputs();
    endtask

    task automatic test_back_to_back_stall();
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h0000_0044;
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h0000_0088;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h44 || ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0 || grant_lsu !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got v=%b a=%h ir=%b lr=%b g=%b exp 1/00000044/0/0/0", i, mem_req_valid, mem_req_addr, ifu_req_ready, lsu_req_ready, grant_lsu); end
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        ifu_req_valid  = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_0077;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (ifu_resp_valid !== 1'b1 || mem_resp_ready !== 1'b0 || mem_req_valid !== 1'b0 || lsu_req_ready !== 1'b0 || grant_lsu !== 1'b0) begin errors++; $display("FAIL stall_resp[%0d]: got v=%b mr=%b mqv=%b lr=%b g=%b exp 1/0/0/0/0", i, ifu_resp_valid, mem_resp_ready, mem_req_valid, lsu_req_ready, grant_lsu); end
            tick();
        end
        ifu_resp_ready = 1'b1;
        #1;
        checks++; if (mem_resp_ready !== 1'b1 || ifu_resp_data !== 32'h77) begin errors++; $display("FAIL stall_release: got r=%b d=%h exp 1/00000077", mem_resp_ready, ifu_resp_data); end
        tick();
        mem_resp_valid = 1'b0;
        ifu_resp_ready = 1'b0;
        tick();
        checks++; if (grant_lsu !== 1'b1 || mem_req_addr !== 32'h88) begin errors++; $display("FAIL stall_lsu_next: got g=%b a=%h exp 1/00000088", grant_lsu, mem_req_addr); end
        mem_req_ready  = 1'b1;
        lsu_resp_ready = 1'b1;
        tick();
        lsu_req_valid  = 1'b0;
        mem_resp_valid = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        ifu_req_valid  = 1'b1;
        ifu_req_addr   = 32'h0000_0200;
        mem_req_ready  = 1'b1;
        ifu_resp_ready = 1'b1;
        tick();
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b0;
        #1;
        checks++; if (mem_resp_ready !== 1'b1) begin errors++; $display("FAIL mid_pre_reset: got %b exp 1", mem_resp_ready); end
        #1;
        rst = 1'b0;
        #1;
        checks++; if (mem_resp_ready !== 1'b0 || grant_lsu !== 1'b0 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL mid_async_reset: got r=%b g=%b v=%b exp 0/0/0", mem_resp_ready, grant_lsu, mem_req_valid); end
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBAD0_BAD0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 || mem_resp_ready !== 1'b0 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL mid_late_resp[%0d]: got iv=%b lv=%b r=%b mv=%b exp 0/0/0/0", i, ifu_resp_valid, lsu_resp_valid, mem_resp_ready, mem_req_valid); end
        end
        clear_inputs();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h0000_0300;
        mem_req_ready = 1'b1;
        mem_resp_data = 32'hFFFF_FFFF;
        tick();
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL timeout_early[%0d]: got %b exp 0", i, ifu_resp_valid); end
            tick();
        end
        checks++; if (ifu_resp_valid !== 1'b1 || ifu_resp_err !== 1'b1 || ifu_resp_data !== 32'h0) begin errors++; $display("FAIL timeout_resp: got v=%b e=%b d=%h exp 1/1/0", ifu_resp_valid, ifu_resp_err, ifu_resp_data); end
        ifu_resp_ready = 1'b1;
        tick();
        checks++; if (ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL timeout_idle: got %b exp 0", ifu_resp_valid); end
        clear_inputs();
    endtask
`endif

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_ifu_read();
        test_both();
        test_store();
        test_back_to_back_stall();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
